ad_iq_capture: RTL and testbench
================================

Name: ad_iq_capture

Overview:
Triggered I/Q snapshot buffer directly downstream of the ADS42 front-end.
- Consumes the 16-bit I and Q sample streams and their valid strobes, in the AD output clock domain.
- After an arm and a trigger rising edge, stores a programmable number of {Q,I} sample pairs in an internal block RAM.
- A host/DSP consumer then reads the stored pairs back through a one-word-per-cycle read port.

Parameters:
DW, 16, width of each I and Q sample
AW, 10, RAM address width; capture depth = 2^AW pairs
DECIM_W, 8, width of decimation control (only used when AD_IQ_CAPTURE_DECIM_EN is defined)

Ports:
sys_clk  in  1  single clock; driven by the AD output clock
rst_n  in  1  asynchronous active-low reset
i_adi_din  in  DW  I sample
i_adi_din_vl  in  1  I sample valid
i_adq_din  in  DW  Q sample
i_adq_din_vl  in  1  Q sample valid
i_arm  in  1  single-cycle arm request
i_trig  in  1  trigger level; rising edge starts capture
i_cap_len  in  AW+1  pairs to capture; 0 or >2^AW means 2^AW
o_busy  out  1  high in WAIT_TRIG or CAPTURE
o_done  out  1  high in DONE (buffer holds a complete capture)
o_sync_err  out  1  sticky: I valid and Q valid disagreed during CAPTURE
i_rd_en  in  1  read request, one word per cycle
o_rd_data  out  2*DW  {Q,I} pair
o_rd_vl  out  1  o_rd_data valid
o_rd_last  out  1  marks the final word of the capture

Behaviour:
- Reset: state IDLE. All outputs are 0: o_busy, o_done, o_sync_err, o_rd_data, o_rd_vl, o_rd_last. Internal counters, trig_d and the latched length are also 0.
- Sample valid: smp_vl = i_adi_din_vl & i_adq_din_vl.
- Sync error: if the two valids differ on any cycle in CAPTURE, set o_sync_err. Only i_arm clears it. That sample is not written.
- Trigger edge: trig_d registers i_trig; trig_edge = i_trig & ~trig_d, evaluated every cycle.
- States: IDLE, WAIT_TRIG, CAPTURE, DONE.
- IDLE: on i_arm, latch the clamped length into len_r, clear the write count, clear o_sync_err, and go to WAIT_TRIG.
- WAIT_TRIG:
  - On trig_edge, go to CAPTURE.
  - If smp_vl is high in the trig_edge cycle, that sample is written at address 0 in the same cycle.
  - If i_arm and trig_edge occur in the same cycle, arm wins: len_r is re-latched and the trigger is ignored.
- CAPTURE:
  - Each kept valid sample is written to RAM[wr_cnt] and wr_cnt increments.
  - When the write that makes wr_cnt == len_r completes, go to DONE. o_done rises the next cycle.
  - i_arm and trig_edge are ignored in this state.
- DONE:
  - The read pointer starts at 0.
  - Each i_rd_en cycle reads RAM[rd_ptr] and increments rd_ptr. Read latency is 1 cycle: o_rd_vl is high the cycle after i_rd_en.
  - Back-to-back i_rd_en gives back-to-back data.
  - o_rd_last is high with the word read at rd_ptr == len_r-1.
  - The cycle that word is presented, the state returns to IDLE and o_done drops.
  - i_rd_en beyond the last word, or while not in DONE, is ignored (o_rd_vl stays 0).
  - i_arm in DONE discards the capture, re-arms (same actions as from IDLE) and aborts any in-flight readout. A read already issued still completes with o_rd_vl, but o_rd_last is not asserted.
- Write/read counters are AW+1 bits, so a full 2^AW capture does not wrap to 0.
- Samples arriving in IDLE, WAIT_TRIG (except the trigger cycle) and DONE are dropped.
- Reset asserted mid-capture or mid-read returns to IDLE immediately. RAM contents are don't-care.

Optional Feature:
AD_IQ_CAPTURE_DECIM_EN
- Defined: adds input i_decim [DECIM_W-1:0], latched at arm. In CAPTURE, only every (i_decim+1)-th valid sample is kept. The decimation counter resets at the trigger, so the trigger-cycle sample is always kept. i_decim = 0 keeps every sample.
- Undefined: the port is absent and every valid sample is kept.

Test Plan:
1. Arm with i_cap_len=8, hold valids high, raise i_trig on cycle T with ramp data I=n, Q=0x8000+n -> o_done at T+9. Reading 8 cycles gives {0x8000+k,k} with k starting at the trigger-cycle sample; o_rd_last on word 8; IDLE after.
2. i_cap_len=0 -> exactly 1024 pairs captured and read back; o_rd_last on word 1024; no address wrap corruption.
3. Trigger held high before arm, then arm -> no capture until i_trig falls and rises again.
4. i_arm and trig rising edge in the same cycle -> stays WAIT_TRIG; a later edge captures.
5. Toggle i_adq_din_vl low for 1 cycle during CAPTURE -> o_sync_err=1, sample skipped, capture still completes with len_r pairs; next i_arm clears the flag.
6. With AD_IQ_CAPTURE_DECIM_EN and i_decim=3, len 4, continuous ramp -> stored samples are trigger sample +0, +4, +8, +12.

Source files
------------

// File: rtl/ad_iq_capture.sv
// Triggered {Q,I} snapshot buffer: arm, wait for a trigger rising edge, capture len pairs, read back.
// Optional AD_IQ_CAPTURE_DECIM_EN adds i_decim to keep only every (i_decim+1)-th valid sample.
module ad_iq_capture #(
  parameter int DW      = 16,
  parameter int AW      = 10,
  parameter int DECIM_W = 8
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic [DW-1:0]     i_adi_din,
  input  logic              i_adi_din_vl,
  input  logic [DW-1:0]     i_adq_din,
  input  logic              i_adq_din_vl,
  input  logic              i_arm,
  input  logic              i_trig,
  input  logic [AW:0]       i_cap_len,
`ifdef AD_IQ_CAPTURE_DECIM_EN
  input  logic [DECIM_W-1:0] i_decim,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_sync_err,
  input  logic              i_rd_en,
  output logic [2*DW-1:0]   o_rd_data,
  output logic              o_rd_vl,
  output logic              o_rd_last
);

  localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

  state_t          state;
  logic            trig_d;
  logic [AW:0]     len_r, wr_cnt, rd_ptr;
  logic [2*DW-1:0] ram [2**AW];

  logic        smp_vl, trig_edge, trig_go, keep, wr_en, wr_last, rd_go, rd_end;
  logic [AW:0] len_clamp, wr_nxt;

  assign smp_vl    = i_adi_din_vl & i_adq_din_vl;
  assign trig_edge = i_trig & ~trig_d;
  assign len_clamp = (i_cap_len == '0 || i_cap_len > FULL) ? FULL : i_cap_len;
  // arm has priority over a simultaneous trigger edge
  assign trig_go   = (state == WAIT_TRIG) && trig_edge && !i_arm;
  assign wr_nxt    = wr_cnt + ONE;

`ifdef AD_IQ_CAPTURE_DECIM_EN
  logic [DECIM_W-1:0] dec_r, dec_cnt, dec_base;

  // trigger cycle behaves as if the decimation counter were already at 0
  assign dec_base = (state == WAIT_TRIG) ? '0 : dec_cnt;
  assign keep     = (dec_base == '0);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_r   <= '0;
      dec_cnt <= '0;
    end else begin
      if (i_arm && state != CAPTURE) dec_r <= i_decim;
      if (trig_go && !smp_vl) dec_cnt <= '0;
      else if ((trig_go || state == CAPTURE) && smp_vl)
        dec_cnt <= (dec_base == dec_r) ? '0 : dec_base + 1'b1;
    end
  end
`else
  assign keep = 1'b1;
`endif

  assign wr_en   = smp_vl && keep && (trig_go || state == CAPTURE);
  assign wr_last = wr_en && (wr_nxt == len_r);
  assign rd_go   = (state == DONE) && i_rd_en && (rd_ptr < len_r);
  assign rd_end  = rd_go && (rd_ptr == len_r - ONE);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      trig_d     <= 1'b0;
      len_r      <= '0;
      wr_cnt     <= '0;
      rd_ptr     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_sync_err <= 1'b0;
    end else begin
      trig_d <= i_trig;
      if (i_arm && state != CAPTURE) begin
        state      <= WAIT_TRIG;
        len_r      <= len_clamp;
        wr_cnt     <= '0;
        rd_ptr     <= '0;
        o_sync_err <= 1'b0;
        o_busy     <= 1'b1;
        o_done     <= 1'b0;
      end else begin
        case (state)
          WAIT_TRIG: if (trig_go) begin
            if (wr_en) wr_cnt <= wr_nxt;
            state  <= wr_last ? DONE : CAPTURE;
            o_busy <= !wr_last;
          end
          CAPTURE: begin
            if (i_adi_din_vl != i_adq_din_vl) o_sync_err <= 1'b1;
            if (wr_en) wr_cnt <= wr_nxt;
            if (wr_last) begin
              state  <= DONE;
              o_busy <= 1'b0;
            end
          end
          DONE: begin
            // o_done lags entry into DONE by one cycle and drops with the last word
            o_done <= !rd_end;
            if (rd_go) rd_ptr <= rd_ptr + ONE;
            if (rd_end) state <= IDLE;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (wr_en) ram[wr_cnt[AW-1:0]] <= {i_adq_din, i_adi_din};
  end

  // a read issued alongside an arm still returns data, but never flagged last
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rd_data <= '0;
      o_rd_vl   <= 1'b0;
      o_rd_last <= 1'b0;
    end else begin
      o_rd_vl   <= rd_go;
      o_rd_last <= rd_end && !i_arm;
      if (rd_go) o_rd_data <= ram[rd_ptr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_ad_iq_capture.sv
// Scoreboard bench for ad_iq_capture: randomized captures checked against a list-based reference model.
module tb_ad_iq_capture;
  localparam int DW = 16, AW = 10, DEPTH = 1 << AW;

  logic          sys_clk = 1'b0, rst_n = 1'b0;
  logic [DW-1:0] i_adi_din = '0, i_adq_din = '0;
  logic          i_adi_din_vl = 1'b0, i_adq_din_vl = 1'b0;
  logic          i_arm = 1'b0, i_trig = 1'b0, i_rd_en = 1'b0;
  logic [AW:0]   i_cap_len = '0;
  logic [7:0]    i_decim = '0;
  logic          o_busy, o_done, o_sync_err, o_rd_vl, o_rd_last;
  logic [2*DW-1:0] o_rd_data;

`ifdef AD_IQ_CAPTURE_DECIM_EN
  localparam bit HAS_DECIM = 1'b1;
`else
  localparam bit HAS_DECIM = 1'b0;
`endif

  ad_iq_capture dut (
    .sys_clk(sys_clk), .rst_n(rst_n),
    .i_adi_din(i_adi_din), .i_adi_din_vl(i_adi_din_vl),
    .i_adq_din(i_adq_din), .i_adq_din_vl(i_adq_din_vl),
    .i_arm(i_arm), .i_trig(i_trig), .i_cap_len(i_cap_len),
`ifdef AD_IQ_CAPTURE_DECIM_EN
    .i_decim(i_decim),
`endif
    .o_busy(o_busy), .o_done(o_done), .o_sync_err(o_sync_err),
    .i_rd_en(i_rd_en), .o_rd_data(o_rd_data), .o_rd_vl(o_rd_vl), .o_rd_last(o_rd_last)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed { logic [2*DW-1:0] data; logic last; } exp_t;
  typedef struct { logic [DW-1:0] i, q; bit vi, vq; } smp_t;

  exp_t exp_q[$];
  smp_t log_q[$];
  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  // monitor: every presented word must match the head of the scoreboard
  always @(negedge sys_clk) begin
    if (rst_n && o_rd_vl) begin
      exp_t e;
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rd_vl actual=%0h required=none", o_rd_data);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", 64'(o_rd_data), 64'(e.data));
        chk("rd_last", 64'(o_rd_last), 64'(e.last));
      end
    end
  end

  function automatic int eff_len(input int len);
    return (len == 0 || len > DEPTH) ? DEPTH : len;
  endfunction

  task automatic set_smp(input smp_t s);
    i_adi_din = s.i; i_adq_din = s.q; i_adi_din_vl = s.vi; i_adq_din_vl = s.vq;
  endtask

  task automatic rand_smp();
    smp_t s;
    s.i = 16'($urandom); s.q = 16'($urandom); s.vi = 1'($urandom); s.vq = s.vi;
    set_smp(s);
  endtask

  task automatic do_arm(input int len, input int dec);
    i_arm = 1'b1; i_cap_len = (AW+1)'(len); i_decim = 8'(dec);
    rand_smp();
    tick();
    i_arm = 1'b0;
    chk("arm_busy", 64'(o_busy), 64'd1);
    chk("arm_done", 64'(o_done), 64'd0);
    chk("arm_sync_clr", 64'(o_sync_err), 64'd0);
  endtask

  // Drive a trigger edge plus a sample stream until o_done, then derive the expected
  // capture from the recorded stream: first len kept valid pairs from the trigger cycle on.
  task automatic capture(input int len, input int dec, input int gap, input int glitch_at, input bit ramp);
    int el, done_j, kept, cnt, last_c;
    bit serr;
    el = eff_len(len); done_j = -1;
    log_q.delete();
    i_trig = 1'b0; rand_smp(); tick();
    for (int j = 0; j < 5000 && done_j < 0; j++) begin
      smp_t s;
      s.vi = ($urandom_range(99) >= gap); s.vq = s.vi;
      if (j == glitch_at) begin s.vi = 1'b1; s.vq = 1'b0; end
      s.i = ramp ? 16'(j) : 16'($urandom);
      s.q = ramp ? 16'(32'h8000 + j) : 16'($urandom);
      set_smp(s); i_trig = 1'b1;
      log_q.push_back(s);
      tick();
      if (o_done) done_j = j;
    end
    kept = 0; cnt = 0; last_c = -1; serr = 1'b0;
    for (int c = 0; c < log_q.size() && kept < el; c++) begin
      if (c > 0 && log_q[c].vi != log_q[c].vq) serr = 1'b1;
      if (log_q[c].vi && log_q[c].vq) begin
        if (cnt == 0) begin
          kept++;
          exp_q.push_back('{data: {log_q[c].q, log_q[c].i}, last: (kept == el)});
          if (kept == el) last_c = c;
        end
        cnt = (cnt == dec) ? 0 : cnt + 1;
      end
    end
    chk("done_cycle", 64'(done_j), 64'(last_c + 1));
    chk("sync_err", 64'(o_sync_err), 64'(serr));
    chk("busy_in_done", 64'(o_busy), 64'd0);
  endtask

  task automatic readout(input int n_req, input int gap);
    int issued = 0;
    for (int k = 0; k < 20000 && issued < n_req; k++) begin
      i_rd_en = ($urandom_range(99) >= gap);
      if (i_rd_en) issued++;
      rand_smp();
      tick();
    end
    i_rd_en = 1'b0;
    tick(); tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    chk("done_after_read", 64'(o_done), 64'd0);
    chk("busy_after_read", 64'(o_busy), 64'd0);
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_sync", 64'(o_sync_err), 64'd0);
    chk("rst_rd_data", 64'(o_rd_data), 64'd0);
    chk("rst_rd_vl", 64'(o_rd_vl), 64'd0);
    chk("rst_rd_last", 64'(o_rd_last), 64'd0);
    #5 rst_n = 1'b1;
    tick();
    chk("idle_busy", 64'(o_busy), 64'd0);

    // ramp capture of 8
    do_arm(8, 0);
    capture(8, 0, 0, -1, 1'b1);
    readout(10, 0);

    // length 0 means full depth, and an oversized length clamps to it
    do_arm(0, 0);
    capture(0, 0, 10, -1, 1'b0);
    readout(DEPTH + 6, 20);
    do_arm(1500, 0);
    capture(1500, 0, 0, -1, 1'b0);
    readout(DEPTH + 2, 0);

    // single-pair capture completes in the trigger cycle
    do_arm(1, 0);
    capture(1, 0, 0, -1, 1'b0);
    readout(3, 0);

    // trigger already high at arm: no capture until a fresh edge
    i_trig = 1'b1; tick(); tick();
    do_arm(5, 0);
    for (int k = 0; k < 10; k++) begin rand_smp(); tick(); end
    chk("held_trig_no_done", 64'(o_done), 64'd0);
    chk("held_trig_busy", 64'(o_busy), 64'd1);
    capture(5, 0, 0, -1, 1'b0);
    readout(5, 30);

    // arm and trigger edge together: arm wins
    i_trig = 1'b0; tick();
    i_arm = 1'b1; i_cap_len = 11'd4; i_trig = 1'b1; rand_smp();
    tick();
    i_arm = 1'b0;
    for (int k = 0; k < 10; k++) begin rand_smp(); tick(); end
    chk("arm_trig_no_done", 64'(o_done), 64'd0);
    chk("arm_trig_busy", 64'(o_busy), 64'd1);
    capture(4, 0, 30, -1, 1'b0);
    readout(6, 10);

    // I/Q valid disagreement mid-capture
    do_arm(12, 0);
    capture(12, 0, 0, 5, 1'b0);
    readout(12, 0);

    if (HAS_DECIM) begin
      do_arm(4, 3);
      capture(4, 3, 0, -1, 1'b1);
      readout(4, 0);
      do_arm(20, 2);
      capture(20, 2, 25, -1, 1'b0);
      readout(22, 20);
    end

    // randomized captures
    for (int r = 0; r < 6; r++) begin
      int len, dec, gap, gl;
      len = $urandom_range(1, 40);
      dec = HAS_DECIM ? $urandom_range(0, 3) : 0;
      gap = $urandom_range(0, 50);
      gl  = ($urandom_range(1) != 0) ? $urandom_range(1, 20) : -1;
      do_arm(len, dec);
      capture(len, dec, gap, gl, 1'b0);
      readout(len + 2, $urandom_range(0, 50));
    end

    // arm during readout: word issued with the arm arrives without last
    do_arm(3, 0);
    capture(3, 0, 0, -1, 1'b0);
    if (exp_q.size() == 3) exp_q[2].last = 1'b0;
    i_rd_en = 1'b1; tick(); tick();
    i_arm = 1'b1; tick();
    i_arm = 1'b0; i_rd_en = 1'b0;
    chk("abort_busy", 64'(o_busy), 64'd1);
    chk("abort_done", 64'(o_done), 64'd0);
    tick();
    chk("abort_drained", 64'(exp_q.size()), 64'd0);
    capture(3, 0, 0, -1, 1'b0);
    readout(3, 0);

    // asynchronous reset mid-capture
    do_arm(50, 0);
    i_trig = 1'b0; tick();
    i_trig = 1'b1;
    for (int k = 0; k < 3; k++) begin rand_smp(); tick(); end
    rst_n = 1'b0; #1;
    chk("midrst_busy", 64'(o_busy), 64'd0);
    chk("midrst_done", 64'(o_done), 64'd0);
    tick();
    rst_n = 1'b1; i_trig = 1'b0;
    i_rd_en = 1'b1; tick(); tick(); i_rd_en = 1'b0;
    tick();
    chk("post_rst_busy", 64'(o_busy), 64'd0);
    chk("final_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
